blur_stream_ctrl: RTL and testbench

Sequences the output side of the 5x5 Gaussian blur stage in the scanner video path. It tracks frame, line and pixel position on the blur's delayed `fvh_out`/`dv_out` stream and classifies each output pixel as interior (valid 5x5 window) or border. It substitutes a configurable border value for border pixels and gates the stream per frame with a frame-latched enable. It reports frame completion and line-length errors to the laser-line detection logic downstream.

---
 rtl/scanner_video_pkg.sv | 33 +++
 rtl/fvh_edge_det.sv | 30 +++
 rtl/blur_stream_ctrl.sv | 156 +++++++++++++++
 tb/tb_blur_stream_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_video_pkg.sv
// Shared types and constants for the scanner video path stream consumers.
package scanner_video_pkg;

  // Bit positions inside the {field, vsync, hsync} control word
  localparam int unsigned FVH_W = 3;
  localparam int unsigned FVH_F = 2;
  localparam int unsigned FVH_V = 1;
  localparam int unsigned FVH_H = 0;

  // Default frame geometry and blur window half-width
  localparam int unsigned IMG_WIDTH_DEF  = 720;
  localparam int unsigned IMG_HEIGHT_DEF = 480;
  localparam int unsigned HALF_K_DEF     = 2;

  // Datapath and counter widths
  localparam int unsigned PX_W  = 8;
  localparam int unsigned COL_W = 10;
  localparam int unsigned ROW_W = 9;
  localparam int unsigned CNT_W = 11;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    SKIP   = 2'd2
  } stream_state_e;

  // Per-frame configuration captured at vsync fall
  typedef struct packed {
    logic            enable;
    logic [PX_W-1:0] border_val;
  } stream_cfg_t;

endpackage

// File: rtl/fvh_edge_det.sv
// Registers the fvh control word and flags vsync/hsync transitions.
module fvh_edge_det
  import scanner_video_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [FVH_W-1:0] fvh_in,
  output logic [FVH_W-1:0] fvh_q,
  output logic             v_rise_c,
  output logic             v_fall_c,
  output logic             h_rise_c,
  output logic             h_fall_c
);

  // One-cycle history of the control word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fvh_q <= '0;
    end else begin
      fvh_q <= fvh_in;
    end
  end

  // Transitions are flagged in the cycle the new level arrives
  assign v_rise_c =  fvh_in[FVH_V] & ~fvh_q[FVH_V];
  assign v_fall_c = ~fvh_in[FVH_V] &  fvh_q[FVH_V];
  assign h_rise_c =  fvh_in[FVH_H] & ~fvh_q[FVH_H];
  assign h_fall_c = ~fvh_in[FVH_H] &  fvh_q[FVH_H];

endmodule

// File: rtl/blur_stream_ctrl.sv
// Output sequencer for the 5x5 blur stage: position tracking, border
// substitution, per-frame gating and line-length error reporting.
module blur_stream_ctrl
  import scanner_video_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned HALF_K     = HALF_K_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  fvh_in,
  input  logic        dv_in,
  input  logic [7:0]  blur_px,
  input  logic        cfg_enable,
  input  logic [7:0]  cfg_border_val,
  input  logic        err_clr,
  output logic [7:0]  px_out,
  output logic        px_valid,
  output logic        px_interior,
  output logic [9:0]  x_out,
  output logic [8:0]  y_out,
  output logic        frame_done,
  output logic        line_err
);

  localparam int unsigned WIN = 2 * HALF_K;

  stream_state_e    state;
  stream_cfg_t      cfg_q;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] col_count;

  logic [FVH_W-1:0] fvh_q;
  logic             v_rise_c;
  logic             v_fall_c;
  logic             h_rise_c;
  logic             h_fall_c;
  logic             unused_fvh;

  logic             active_c;
  logic [CNT_W-1:0] line_len_c;
  logic             line_bad_c;
  logic             err_set_c;
  logic             interior_c;
  logic [COL_W-1:0] x_c;
  logic [ROW_W-1:0] y_c;
  logic [COL_W-1:0] col_inc_c;
  logic [ROW_W-1:0] row_inc_c;

  fvh_edge_det u_fvh_edge_det (
    .clk      (clk),
    .reset    (reset),
    .fvh_in   (fvh_in),
    .fvh_q    (fvh_q),
    .v_rise_c (v_rise_c),
    .v_fall_c (v_fall_c),
    .h_rise_c (h_rise_c),
    .h_fall_c (h_fall_c)
  );

  // Field bit and hsync fall are not needed by this consumer
  assign unused_fvh = ^{fvh_q, h_fall_c};

  // Line length includes a pixel arriving with the hsync rise
  assign active_c   = (state == ACTIVE);
  assign line_len_c = col_count + CNT_W'(dv_in);
  assign line_bad_c = (line_len_c != CNT_W'(IMG_WIDTH)) && (line_len_c != '0);
  assign err_set_c  = active_c && h_rise_c && line_bad_c;

  // Window classification and window-center coordinates of the current pixel
  assign interior_c = (col >= COL_W'(WIN)) && (row >= ROW_W'(WIN));
  assign x_c = (col < COL_W'(HALF_K)) ? col + COL_W'(IMG_WIDTH - HALF_K)
                                      : col - COL_W'(HALF_K);
  assign y_c = (row < ROW_W'(HALF_K)) ? '0 : row - ROW_W'(HALF_K);

  // Saturating position increments
  assign col_inc_c = (col == COL_W'(IMG_WIDTH - 1))  ? col : col + COL_W'(1);
  assign row_inc_c = (row == ROW_W'(IMG_HEIGHT - 1)) ? row : row + ROW_W'(1);

  // Frame FSM, position counters, output pipeline and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      cfg_q       <= '0;
      col         <= '0;
      row         <= '0;
      col_count   <= '0;
      px_out      <= '0;
      px_valid    <= 1'b0;
      px_interior <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      px_valid   <= active_c & dv_in;

      if (active_c && dv_in) begin
        px_out      <= interior_c ? blur_px : cfg_q.border_val;
        px_interior <= interior_c;
        x_out       <= x_c;
        y_out       <= y_c;
      end

      if (err_set_c) begin
        line_err <= 1'b1;
      end else if (err_clr) begin
        line_err <= 1'b0;
      end

      case (state)
        ACTIVE: begin
          if (dv_in) begin
            col       <= col_inc_c;
            col_count <= col_count + CNT_W'(1);
          end
          if (h_rise_c) begin
            if (line_len_c != '0) begin
              row <= row_inc_c;
            end
            col       <= '0;
            col_count <= '0;
          end
          if (v_rise_c) begin
            frame_done <= 1'b1;
            state      <= SYNC;
          end
        end
        SKIP: begin
          if (v_rise_c) begin
            state <= SYNC;
          end
        end
        SYNC: begin
          state <= SYNC;
        end
        default: begin
          state <= SYNC;
        end
      endcase

      // Frame start overrides everything: capture config and restart counting
      if (v_fall_c) begin
        cfg_q     <= '{enable: cfg_enable, border_val: cfg_border_val};
        col       <= '0;
        row       <= '0;
        col_count <= '0;
        state     <= cfg_enable ? ACTIVE : SKIP;
      end
    end
  end

endmodule

// File: tb/tb_blur_stream_ctrl.sv
// Randomized scoreboard bench for blur_stream_ctrl.
module tb_blur_stream_ctrl;

  localparam int W  = 720;
  localparam int H  = 8;
  localparam int HK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fvh_in;
  logic       dv_in;
  logic [7:0] blur_px;
  logic       cfg_enable;
  logic [7:0] cfg_border_val;
  logic       err_clr;
  logic [7:0] px_out;
  logic       px_valid;
  logic       px_interior;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic       frame_done;
  logic       line_err;

  typedef struct {
    logic [7:0] px;
    logic       inter;
    logic [9:0] x;
    logic [8:0] y;
  } exp_px_t;

  typedef struct {
    int len;
    bit coinc;
    int clr;
  } line_t;

  exp_px_t pq[$];
  exp_px_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  bit m_pv, m_fd, m_err;
  bit e_pv, e_fd, e_err;

  blur_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HALF_K(HK)) dut (
    .clk            (clk),
    .reset          (reset),
    .fvh_in         (fvh_in),
    .dv_in          (dv_in),
    .blur_px        (blur_px),
    .cfg_enable     (cfg_enable),
    .cfg_border_val (cfg_border_val),
    .err_clr        (err_clr),
    .px_out         (px_out),
    .px_valid       (px_valid),
    .px_interior    (px_interior),
    .x_out          (x_out),
    .y_out          (y_out),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs appear one clock after the stimulus cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_pv  <= 1'b0;
      e_fd  <= 1'b0;
      e_err <= 1'b0;
    end else begin
      e_pv  <= m_pv;
      e_fd  <= m_fd;
      e_err <= m_err;
    end
  end

  // Monitor: control outputs every cycle, pixel payload whenever valid
  always @(negedge clk) begin
    chk("px_valid", px_valid, e_pv);
    chk("frame_done", frame_done, e_fd);
    chk("line_err", line_err, e_err);
    if (px_valid === 1'b1) begin
      chk("px_queue_level", (pq.size() > 0), 1);
      if (pq.size() > 0) begin
        mon_e = pq.pop_front();
        chk("px_out", px_out, mon_e.px);
        chk("px_interior", px_interior, mon_e.inter);
        chk("x_out", x_out, mon_e.x);
        chk("y_out", y_out, mon_e.y);
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic d, input logic [7:0] p, input logic clr);
    @(posedge clk); #1;
    fvh_in  = f;
    dv_in   = d;
    blur_px = p;
    err_clr = clr;
    m_pv    = 1'b0;
    m_fd    = 1'b0;
  endtask

  // Reference: pixel i of a line, row = number of earlier non-empty lines
  task automatic push_px(input bit act, input int i, input int row, input logic [7:0] v,
                         input logic [7:0] border);
    exp_px_t e;
    int c, r;
    if (!act) return;
    c = (i > W - 1) ? W - 1 : i;
    r = (row > H - 1) ? H - 1 : row;
    e.inter = (c >= 2 * HK) && (r >= 2 * HK);
    e.px    = e.inter ? v : border;
    e.x     = 10'((c + W - HK) % W);
    e.y     = 9'((r < HK) ? 0 : r - HK);
    pq.push_back(e);
    m_pv = 1'b1;
  endtask

  task automatic send_line(input line_t ln, input bit act, inout int row, input logic [7:0] border);
    int n = 0;
    int body;
    logic [7:0] v;
    logic clr;
    body = ln.coinc ? ln.len - 1 : ln.len;
    drive(3'b000, 1'b0, 8'h00, 1'b0);
    while (n < body) begin
      if ($urandom_range(0, 15) == 0) begin
        drive(3'b000, 1'b0, 8'($urandom), 1'b0);
      end else begin
        v = 8'($urandom);
        drive(3'b000, 1'b1, v, 1'b0);
        push_px(act, n, row, v, border);
        n++;
      end
    end
    v   = 8'($urandom);
    clr = (ln.clr == 1);
    drive(3'b001, ln.coinc, v, clr);
    if (ln.coinc) begin
      push_px(act, n, row, v, border);
      n++;
    end
    if (act && n != W && n != 0) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (act && n > 0) row++;
    for (int k = 0; k < 6; k++) begin
      clr = (ln.clr == 2 && k == 2);
      drive(3'b001, 1'b0, 8'h00, clr);
      if (clr) m_err = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_px_out"}, px_out, 0);
    chk({tag, "_px_valid"}, px_valid, 0);
    chk({tag, "_px_interior"}, px_interior, 0);
    chk({tag, "_x_out"}, x_out, 0);
    chk({tag, "_y_out"}, y_out, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_line_err"}, line_err, 0);
  endtask

  task automatic do_reset();
    drive(3'b001, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    dv_in = 1'b0;
    m_pv  = 1'b0;
    m_fd  = 1'b0;
    m_err = 1'b0;
    #2;
    check_zero("midrst");
    chk("midrst_queue_empty", pq.size(), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send_frame(input bit do_vfall, input bit en, input logic [7:0] border,
                            input line_t lines[$], input int rst_before);
    bit act = 1'b0;
    int row = 0;
    for (int k = 0; k < 4; k++) drive(3'b011, 1'b0, 8'h00, 1'b0);
    if (do_vfall) begin
      cfg_enable     = en;
      cfg_border_val = border;
      drive(3'b001, 1'b0, 8'h00, 1'b0);
      act = en;
    end
    foreach (lines[li]) begin
      if (li == 1) begin
        cfg_enable     = ~en;
        cfg_border_val = ~border;
      end
      if (li == rst_before) begin
        do_reset();
        act = 1'b0;
      end
      send_line(lines[li], act, row, border);
    end
    drive(3'b011, 1'b0, 8'h00, 1'b0);
    m_fd = act;
    for (int k = 0; k < 3; k++) drive(3'b011, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_t ls[$];
    int t;
    reset          = 1'b1;
    fvh_in         = 3'b011;
    dv_in          = 1'b0;
    blur_px        = 8'h00;
    cfg_enable     = 1'b0;
    cfg_border_val = 8'h00;
    err_clr        = 1'b0;
    #1 reset = 1'b0;
    #2 check_zero("rst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Enabled frame, more lines than the height to reach row saturation
    ls = {};
    for (int i = 0; i < 10; i++) ls.push_back('{720, 1'b0, 0});
    send_frame(1'b1, 1'b1, 8'h10, ls, -1);

    // Disabled frame with enable raised mid-frame
    ls = {};
    for (int i = 0; i < 3; i++) ls.push_back('{720, 1'b0, 0});
    send_frame(1'b1, 1'b0, 8'h55, ls, -1);

    // Line-length errors, clear priority, coincidence and overlong line
    ls = {};
    ls.push_back('{720, 1'b0, 0});
    ls.push_back('{719, 1'b0, 0});
    ls.push_back('{720, 1'b0, 2});
    ls.push_back('{719, 1'b0, 1});
    ls.push_back('{720, 1'b0, 2});
    ls.push_back('{720, 1'b1, 0});
    ls.push_back('{722, 1'b0, 0});
    ls.push_back('{0,   1'b0, 2});
    ls.push_back('{720, 1'b0, 0});
    send_frame(1'b1, 1'b1, 8'hA7, ls, -1);

    // Reset in the middle of a frame, then finish the partial frame
    ls = {};
    ls.push_back('{720, 1'b0, 0});
    ls.push_back('{719, 1'b0, 0});
    ls.push_back('{720, 1'b0, 0});
    ls.push_back('{720, 1'b0, 0});
    ls.push_back('{720, 1'b0, 0});
    send_frame(1'b1, 1'b1, 8'h3C, ls, 3);

    // Clean frame after the reset
    ls = {};
    for (int i = 0; i < 5; i++) ls.push_back('{720, 1'b0, 0});
    send_frame(1'b1, 1'b1, 8'hE1, ls, -1);

    // Randomized frames
    for (int f = 0; f < 2; f++) begin
      ls = {};
      for (int i = 0; i < 6; i++) begin
        t = $urandom_range(0, 9);
        if (t <= 5)      ls.push_back('{720, 1'b0, 0});
        else if (t == 6) ls.push_back('{719, 1'b0, 1});
        else if (t == 7) ls.push_back('{720, 1'b1, 2});
        else if (t == 8) ls.push_back('{721, 1'b0, 0});
        else             ls.push_back('{0,   1'b0, 2});
      end
      send_frame(1'b1, ($urandom_range(0, 3) != 0), 8'($urandom), ls, -1);
    end

    for (int k = 0; k < 4; k++) drive(3'b011, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("queue_drained", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
